// File: rtl/ddr_frame_writer_pkg.sv
// Shared types and constants for the DDR frame writer.
package ddr_frame_writer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        LOAD,
        ACTIVE
    } state_t;

    localparam int WFIFO_W = 32;
    localparam int PIX_W   = 24;

    // Line/frame counters cover the full 1080p geometry plus the saturation slot.
    localparam int CNT_W  = 12;
    localparam int LOAD_W = 4;
    localparam int FCNT_W = 16;

    // Upper byte of every write-FIFO word.
    localparam logic [WFIFO_W-PIX_W-1:0] PIX_PAD = 8'h00;

endpackage

// File: rtl/ddr_frame_writer_vs_edge_sync.sv
// Calibration-done synchronizer plus vsync polarity normalizer and
// rising-edge detector. The edge output is combinational from two
// registered copies of the normalized vsync, so it is glitch-free.
module vs_edge_sync #(
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic init_calib_complete,
    input  logic in_vsync,
    output logic cal_s,
    output logic vs_edge
);

    logic cal_meta;
    logic vs_act_q;
    logic vs_act_d;

    // Two-flop synchronizer for calibration and vsync history registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cal_meta <= 1'b0;
            cal_s    <= 1'b0;
            vs_act_q <= 1'b0;
            vs_act_d <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop takes its neighbour's pre-edge value;
            // blocking here would collapse the two sync stages into one.
            cal_meta <= init_calib_complete;
            cal_s    <= cal_meta;
            vs_act_q <= in_vsync ~^ VSYNC_POL;
            vs_act_d <= vs_act_q;
        end
    end

    assign vs_edge = vs_act_q & ~vs_act_d;

endmodule

// File: rtl/ddr_frame_writer.sv
// Pixel-stream-to-DDR3 write stage: frame-start address reload, pixel
// packing into 32-bit FIFO words, geometry clamping and sticky error flags.
module ddr_frame_writer
    import ddr_frame_writer_pkg::*;
#(
    parameter int   H_VISIBLE   = 1920,
    parameter int   V_VISIBLE   = 1080,
    parameter int   LOAD_CYCLES = 4,
    parameter logic VSYNC_POL   = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               init_calib_complete,
    input  logic               in_vsync,
    input  logic               in_den,
    input  logic [PIX_W-1:0]   in_pixel,
    input  logic               clear_err,
    output logic               wr_load,
    output logic               wfifo_wren,
    output logic [WFIFO_W-1:0] wfifo_din,
    output logic               frame_done,
    output logic [FCNT_W-1:0]  frame_cnt,
    output logic               err_short_line,
    output logic               err_long_line,
    output logic               err_frame_size,
    output logic               busy
);

    localparam logic [CNT_W-1:0]  H_LIM     = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0]  V_LIM     = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0]  H_SAT     = CNT_W'(H_VISIBLE + 1);
    localparam logic [CNT_W-1:0]  V_SAT     = CNT_W'(V_VISIBLE + 1);
    localparam logic [LOAD_W-1:0] LOAD_INIT = LOAD_W'(LOAD_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   x;
    logic [CNT_W-1:0]   y;
    logic [LOAD_W-1:0]  load_cnt;
    logic               den_q;
    logic               cal_s;
    logic               vs_edge;

    vs_edge_sync #(
        .VSYNC_POL (VSYNC_POL)
    ) u_vs_edge_sync (
        .clk                 (clk),
        .reset_n             (reset_n),
        .init_calib_complete (init_calib_complete),
        .in_vsync            (in_vsync),
        .cal_s               (cal_s),
        .vs_edge             (vs_edge)
    );

    // Frame FSM with x/y geometry counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            x              <= '0;
            y              <= '0;
            load_cnt       <= '0;
            den_q          <= 1'b0;
            wr_load        <= 1'b0;
            wfifo_wren     <= 1'b0;
            wfifo_din      <= '0;
            frame_done     <= 1'b0;
            frame_cnt      <= '0;
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
            err_frame_size <= 1'b0;
            busy           <= 1'b0;
        end else begin
            wfifo_wren <= 1'b0;
            wr_load    <= 1'b0;
            frame_done <= 1'b0;
            den_q      <= 1'b0;

            // Clear is applied first so any error set later in this block wins.
            if (clear_err) begin
                err_short_line <= 1'b0;
                err_long_line  <= 1'b0;
                err_frame_size <= 1'b0;
            end

            if (!cal_s) begin
                // Calibration lost: abandon the frame, keep errors and frame count.
                state <= IDLE;
                busy  <= 1'b0;
                x     <= '0;
                y     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_VS;
                        busy  <= 1'b0;
                    end

                    WAIT_VS: begin
                        if (vs_edge) begin
                            state    <= LOAD;
                            load_cnt <= LOAD_INIT;
                            wr_load  <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end

                    LOAD: begin
                        // Pixels arriving before the address reload finishes are lost.
                        if (in_den) begin
                            err_frame_size <= 1'b1;
                        end
                        if (load_cnt == '0) begin
                            state <= ACTIVE;
                        end else begin
                            load_cnt <= load_cnt - 1'b1;
                            wr_load  <= 1'b1;
                        end
                    end

                    ACTIVE: begin
                        if (vs_edge) begin
                            if (y != V_LIM) begin
                                err_frame_size <= 1'b1;
                            end
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 1'b1;
                            x          <= '0;
                            y          <= '0;
                            state      <= LOAD;
                            load_cnt   <= LOAD_INIT;
                            wr_load    <= 1'b1;
                        end else if (in_den) begin
                            den_q <= 1'b1;
                            if (x < H_LIM) begin
                                if (y < V_LIM) begin
                                    wfifo_wren <= 1'b1;
                                    wfifo_din  <= {PIX_PAD, in_pixel};
                                end
                                x <= x + 1'b1;
                            end else begin
                                err_long_line <= 1'b1;
                                if (x != H_SAT) begin
                                    x <= x + 1'b1;
                                end
                            end
                        end else if (den_q) begin
                            // End of line on the den falling edge.
                            if (x != '0 && x < H_LIM) begin
                                err_short_line <= 1'b1;
                            end
                            if (y != V_SAT) begin
                                y <= y + 1'b1;
                            end
                            x <= '0;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Directed bench for ddr_frame_writer with an 8x4 frame geometry.
module tb_ddr_frame_writer;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int LC = 4;

    logic        clk                 = 1'b0;
    logic        reset_n             = 1'b0;
    logic        init_calib_complete = 1'b0;
    logic        in_vsync            = 1'b0;
    logic        in_den              = 1'b0;
    logic [23:0] in_pixel            = '0;
    logic        clear_err           = 1'b0;
    logic        wr_load;
    logic        wfifo_wren;
    logic [31:0] wfifo_din;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_short_line;
    logic        err_long_line;
    logic        err_frame_size;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Owned by the monitor process.
    logic [31:0] wq[$];
    int          load_cycles  = 0;
    int          done_pulses  = 0;
    int          done_aligned = 0;
    logic        load_q       = 1'b0;

    // Owned by the stimulus process.
    logic [31:0] eq[$];

    ddr_frame_writer #(
        .H_VISIBLE   (H),
        .V_VISIBLE   (V),
        .LOAD_CYCLES (LC),
        .VSYNC_POL   (1'b1)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .init_calib_complete (init_calib_complete),
        .in_vsync            (in_vsync),
        .in_den              (in_den),
        .in_pixel            (in_pixel),
        .clear_err           (clear_err),
        .wr_load             (wr_load),
        .wfifo_wren          (wfifo_wren),
        .wfifo_din           (wfifo_din),
        .frame_done          (frame_done),
        .frame_cnt           (frame_cnt),
        .err_short_line      (err_short_line),
        .err_long_line       (err_long_line),
        .err_frame_size      (err_frame_size),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    // Record writes, reload width and frame_done alignment on the falling edge.
    always @(negedge clk) begin
        if (wfifo_wren === 1'b1) wq.push_back(wfifo_din);
        if (wr_load === 1'b1) load_cycles++;
        if (frame_done === 1'b1) begin
            done_pulses++;
            if (wr_load === 1'b1 && load_q === 1'b0) done_aligned++;
        end
        load_q = wr_load;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int n, input int y, input bit expect_wr);
        for (int i = 0; i < n; i++) begin
            in_den   = 1'b1;
            in_pixel = {8'h00, 4'h0, 4'(y), 4'h0, 4'(i)};
            if (expect_wr && i < H && y < V) eq.push_back({8'h00, in_pixel});
            tick();
        end
        in_den = 1'b0;
        tick();
        tick();
    endtask

    task automatic vsync();
        in_vsync = 1'b1;
        tick();
        in_vsync = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset(input string tag);
        reset_n = 1'b0;
        tick();
        checks++;
        if ({wr_load, wfifo_wren, frame_done, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_ctrl got %b want 0000", tag, {wr_load, wfifo_wren, frame_done, busy});
        end
        checks++;
        if ({err_short_line, err_long_line, err_frame_size} !== 3'b000) begin
            errors++;
            $display("FAIL %s_errs got %b want 000", tag, {err_short_line, err_long_line, err_frame_size});
        end
        checks++;
        if (frame_cnt !== 16'd0 || wfifo_din !== 32'd0) begin
            errors++;
            $display("FAIL %s_cnt_din got %h/%h want 0000/00000000", tag, frame_cnt, wfifo_din);
        end
        reset_n = 1'b1;
        in_den  = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int wb, lb, db, ab;
        init_calib_complete = 1'b1;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL nominal_wait_busy got %b want 0", busy);
        end
        lb = load_cycles;
        db = done_pulses;
        vsync();
        checks++;
        if (load_cycles - lb != LC) begin
            errors++;
            $display("FAIL nominal_first_load got %0d want %0d", load_cycles - lb, LC);
        end
        checks++;
        if (done_pulses != db || busy !== 1'b1) begin
            errors++;
            $display("FAIL nominal_first_vs got done %0d busy %b want done 0 busy 1", done_pulses - db, busy);
        end
        for (int f = 0; f < 2; f++) begin
            eq.delete();
            wb = wq.size();
            for (int y = 0; y < V; y++) send_line(H, y, 1'b1);
            checks++;
            if (wq.size() - wb != 32) begin
                errors++;
                $display("FAIL nominal_count got %0d want 32", wq.size() - wb);
            end
            for (int i = 0; i < eq.size() && wb + i < wq.size(); i++) begin
                checks++;
                if (wq[wb+i] !== eq[i]) begin
                    errors++;
                    $display("FAIL nominal_din[%0d] got %h want %h", i, wq[wb+i], eq[i]);
                end
            end
            lb = load_cycles;
            db = done_pulses;
            ab = done_aligned;
            vsync();
            checks++;
            if (frame_cnt !== 16'(f + 1)) begin
                errors++;
                $display("FAIL nominal_frame_cnt got %0d want %0d", frame_cnt, f + 1);
            end
            checks++;
            if (load_cycles - lb != LC || done_pulses - db != 1 || done_aligned - ab != 1) begin
                errors++;
                $display("FAIL nominal_close got load %0d done %0d aligned %0d want %0d 1 1",
                         load_cycles - lb, done_pulses - db, done_aligned - ab, LC);
            end
        end
        checks++;
        if ({err_short_line, err_long_line, err_frame_size} !== 3'b000) begin
            errors++;
            $display("FAIL nominal_errs got %b want 000", {err_short_line, err_long_line, err_frame_size});
        end
    endtask

    task automatic test_long_line();
        int wb;
        eq.delete();
        wb = wq.size();
        send_line(10, 0, 1'b1);
        for (int y = 1; y < V; y++) send_line(H, y, 1'b1);
        checks++;
        if (wq.size() - wb != 32) begin
            errors++;
            $display("FAIL long_count got %0d want 32", wq.size() - wb);
        end
        for (int i = 0; i < eq.size() && wb + i < wq.size(); i++) begin
            checks++;
            if (wq[wb+i] !== eq[i]) begin
                errors++;
                $display("FAIL long_din[%0d] got %h want %h", i, wq[wb+i], eq[i]);
            end
        end
        vsync();
        checks++;
        if ({err_short_line, err_long_line, err_frame_size} !== 3'b010 || frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL long_flags got errs %b cnt %0d want 010 cnt 3",
                     {err_short_line, err_long_line, err_frame_size}, frame_cnt);
        end
    endtask

    task automatic test_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checks++;
        if ({err_short_line, err_long_line, err_frame_size} !== 3'b000) begin
            errors++;
            $display("FAIL clear_only got %b want 000", {err_short_line, err_long_line, err_frame_size});
        end
        for (int i = 0; i < 9; i++) begin
            in_den    = 1'b1;
            in_pixel  = {8'h00, 4'h0, 4'h0, 4'h0, 4'(i)};
            clear_err = (i == 8);
            tick();
            clear_err = 1'b0;
        end
        checks++;
        if (err_long_line !== 1'b1) begin
            errors++;
            $display("FAIL clear_vs_set got %b want 1", err_long_line);
        end
        in_den = 1'b0;
        tick();
        tick();
        for (int y = 1; y < V; y++) send_line(H, y, 1'b0);
        vsync();
        checks++;
        if (frame_cnt !== 16'd4 || err_frame_size !== 1'b0) begin
            errors++;
            $display("FAIL clear_frame got cnt %0d fsize %b want 4 0", frame_cnt, err_frame_size);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    task automatic test_short_frame();
        int wb;
        wb = wq.size();
        for (int y = 0; y < 3; y++) send_line(6, y, 1'b0);
        checks++;
        if (wq.size() - wb != 18) begin
            errors++;
            $display("FAIL short_count got %0d want 18", wq.size() - wb);
        end
        vsync();
        checks++;
        if ({err_short_line, err_long_line, err_frame_size} !== 3'b101 || frame_cnt !== 16'd5) begin
            errors++;
            $display("FAIL short_flags got errs %b cnt %0d want 101 cnt 5",
                     {err_short_line, err_long_line, err_frame_size}, frame_cnt);
        end
    endtask

    task automatic test_calib_loss();
        int wb, lb, db;
        wb = wq.size();
        for (int i = 0; i < 8; i++) begin
            in_den   = 1'b1;
            in_pixel = {8'h00, 4'h0, 4'h0, 4'h0, 4'(i)};
            if (i == 3) init_calib_complete = 1'b0;
            tick();
            if (i >= 5) begin
                checks++;
                if (wfifo_wren !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL calib_drop_px%0d got wren %b busy %b want 0 0", i, wfifo_wren, busy);
                end
            end
        end
        in_den = 1'b0;
        tick();
        checks++;
        if (wq.size() - wb < 3 || wq.size() - wb > 6) begin
            errors++;
            $display("FAIL calib_drop_writes got %0d want 3..6", wq.size() - wb);
        end
        checks++;
        if ({err_short_line, err_frame_size} !== 2'b11 || frame_cnt !== 16'd5) begin
            errors++;
            $display("FAIL calib_hold got errs %b cnt %0d want 11 cnt 5",
                     {err_short_line, err_frame_size}, frame_cnt);
        end
        clear_err           = 1'b1;
        init_calib_complete = 1'b1;
        tick();
        clear_err = 1'b0;
        repeat (4) tick();
        wb = wq.size();
        send_line(H, 0, 1'b0);
        checks++;
        if (wq.size() != wb) begin
            errors++;
            $display("FAIL calib_wait_writes got %0d want 0", wq.size() - wb);
        end
        lb = load_cycles;
        db = done_pulses;
        vsync();
        checks++;
        if (load_cycles - lb != LC || done_pulses != db || frame_cnt !== 16'd5) begin
            errors++;
            $display("FAIL calib_resume got load %0d done %0d cnt %0d want %0d 0 5",
                     load_cycles - lb, done_pulses - db, frame_cnt, LC);
        end
        wb = wq.size();
        for (int y = 0; y < V; y++) send_line(H, y, 1'b0);
        checks++;
        if (wq.size() - wb != 32 || {err_short_line, err_long_line, err_frame_size} !== 3'b000) begin
            errors++;
            $display("FAIL calib_frame got writes %0d errs %b want 32 000",
                     wq.size() - wb, {err_short_line, err_long_line, err_frame_size});
        end
    endtask

    task automatic test_den_in_load();
        int wb, lb, db;
        wb = wq.size();
        lb = load_cycles;
        db = done_pulses;
        in_vsync = 1'b1;
        tick();
        in_vsync = 1'b0;
        tick();
        in_den   = 1'b1;
        in_pixel = 24'hABCDEF;
        tick();
        in_den = 1'b0;
        repeat (7) tick();
        checks++;
        if (err_frame_size !== 1'b1 || wq.size() != wb) begin
            errors++;
            $display("FAIL load_den got fsize %b writes %0d want 1 0", err_frame_size, wq.size() - wb);
        end
        checks++;
        if (frame_cnt !== 16'd6 || done_pulses - db != 1 || load_cycles - lb != LC) begin
            errors++;
            $display("FAIL load_den_close got cnt %0d done %0d load %0d want 6 1 %0d",
                     frame_cnt, done_pulses - db, load_cycles - lb, LC);
        end
    endtask

    initial begin
        test_reset("reset_init");
        test_nominal();
        test_long_line();
        test_clear();
        test_short_frame();
        test_calib_loss();
        test_den_in_load();
        for (int i = 0; i < 3; i++) begin
            in_den   = 1'b1;
            in_pixel = {8'h00, 4'h0, 4'h0, 4'h0, 4'(i)};
            tick();
        end
        test_reset("reset_mid");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
